// File: rtl/task_arb_pkg.sv
// Shared types and constants for the task answer arbiter: FSM state
// encoding, the abort marker word, header field layout and the size
// saturation helper used when building the first header word.
package task_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_SIZE,
    HDR_LAT,
    PAYLOAD,
    ABORT
  } task_arb_state_e;

  localparam logic [31:0] ABORT_WORD = 32'hDEAD_BEEF;

  localparam int HDR_ID_MSB = 31;
  localparam int HDR_ID_LSB = 24;
  localparam int HDR_SIZE_W = 24;

  // Clamp a byte count to the header size field, saturating at all ones
  function automatic logic [HDR_SIZE_W-1:0] sat_size(input logic [31:0] size);
    logic [31:0] size_max;
    size_max = {{(32-HDR_SIZE_W){1'b0}}, {HDR_SIZE_W{1'b1}}};
    if (size > size_max) begin
      sat_size = size_max[HDR_SIZE_W-1:0];
    end else begin
      sat_size = size[HDR_SIZE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/task_answer_arbiter_rr_picker.sv
// Circular priority encoder: returns the first requesting index found when
// scanning upward from rr_ptr and wrapping around at NUM_TASKS.
module rr_picker #(
  parameter  int NUM_TASKS = 4,
  localparam int ID_W      = $clog2(NUM_TASKS)
) (
  input  logic [NUM_TASKS-1:0] req,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 found,
  output logic [ID_W-1:0]      idx
);

  // Walk the requesters starting at the pointer and keep the first hit
  always_comb begin
    int cand;
    logic [ID_W-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_TASKS;
      cand_idx = cand[ID_W-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/task_answer_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_TASKS answer streams into one
// 32-bit stream. A granted task keeps the output until its last word (or a
// watchdog abort), so packets are never interleaved.
// Optional feature macro: TASK_ARB_HEADER_EN adds a two-word header
// ({id, saturated size} then latency) in front of every packet.
module task_answer_arbiter
  import task_arb_pkg::*;
#(
  parameter  int NUM_TASKS      = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_TASKS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_TASKS-1:0]       i_req_valid,
  input  logic [NUM_TASKS-1:0][31:0] i_req_data,
  input  logic [NUM_TASKS-1:0]       i_req_last,
  output logic [NUM_TASKS-1:0]       o_req_ready,
  input  logic [NUM_TASKS-1:0][31:0] i_req_size,
  input  logic [NUM_TASKS-1:0][31:0] i_req_lat,
  output logic [31:0]                o_data,
  output logic                       o_valid,
  output logic                       o_last,
  input  logic                       i_ready,
  output logic [ID_W-1:0]            o_grant_id,
  output logic                       o_busy,
  output logic                       o_timeout
);

  task_arb_state_e state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] next_ptr;
  logic [31:0]     wd_cnt;
  logic [31:0]     wd_inc;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            beat;

`ifdef TASK_ARB_HEADER_EN
  logic [31:0] size_q;
  logic [31:0] lat_q;
`else
  logic unused_hdr_inputs;
  assign unused_hdr_inputs = ^{i_req_size, i_req_lat};
`endif

  rr_picker #(
    .NUM_TASKS(NUM_TASKS)
  ) u_picker (
    .req   (i_req_valid),
    .rr_ptr(rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr   = (grant == ID_W'(NUM_TASKS - 1)) ? '0 : grant + ID_W'(1);
  assign wd_inc     = (wd_cnt == '1) ? wd_cnt : wd_cnt + 32'd1;
  assign beat       = (state == PAYLOAD) && i_req_valid[grant] && i_ready;
  assign o_grant_id = grant;
  assign o_busy     = (state != IDLE);

  // Packet sequencing: grant, optional header, payload, watchdog abort
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
`ifdef TASK_ARB_HEADER_EN
      size_q    <= '0;
      lat_q     <= '0;
`endif
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (pick_found) begin
            grant  <= pick_idx;
`ifdef TASK_ARB_HEADER_EN
            size_q <= i_req_size[pick_idx];
            lat_q  <= i_req_lat[pick_idx];
            state  <= HDR_SIZE;
`else
            state  <= PAYLOAD;
`endif
          end
        end
`ifdef TASK_ARB_HEADER_EN
        HDR_SIZE: begin
          if (i_ready) begin
            state <= HDR_LAT;
          end
        end
        HDR_LAT: begin
          if (i_ready) begin
            state  <= PAYLOAD;
            wd_cnt <= '0;
          end
        end
`endif
        PAYLOAD: begin
          if (beat) begin
            wd_cnt <= '0;
            if (i_req_last[grant]) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end else if (!i_req_valid[grant]) begin
            wd_cnt <= wd_inc;
            if ((TIMEOUT_CYCLES != 0) && (wd_inc >= 32'(TIMEOUT_CYCLES))) begin
              state <= ABORT;
            end
          end
        end
        ABORT: begin
          if (i_ready) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
            rr_ptr    <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: header words, granted task pass-through or abort marker
  always_comb begin
    o_valid     = 1'b0;
    o_data      = '0;
    o_last      = 1'b0;
    o_req_ready = '0;
    case (state)
`ifdef TASK_ARB_HEADER_EN
      HDR_SIZE: begin
        o_valid                           = 1'b1;
        o_data[HDR_ID_MSB:HDR_ID_LSB]     = {{(HDR_ID_MSB-HDR_ID_LSB+1-ID_W){1'b0}}, grant};
        o_data[HDR_SIZE_W-1:0]            = sat_size(size_q);
      end
      HDR_LAT: begin
        o_valid = 1'b1;
        o_data  = lat_q;
      end
`endif
      PAYLOAD: begin
        o_valid            = i_req_valid[grant];
        o_data             = i_req_data[grant];
        o_last             = i_req_last[grant];
        o_req_ready[grant] = i_ready;
      end
      ABORT: begin
        o_valid = 1'b1;
        o_data  = ABORT_WORD;
        o_last  = 1'b1;
      end
      default: begin
        o_valid = 1'b0;
      end
    endcase
  end

endmodule
